// File: rtl/regfile_secure_mp.sv
// regfile_secure_mp: register file with three registered read ports, two write
// ports (memory and ALU writeback), x0 hardwired to zero, and a protected
// register window gated by a key-unlock FSM. The FSM has an auto-relock timer,
// a wrong-key lockout penalty, and a saturating count of dropped writes.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   rd_addrN / rd_dataN (N=1..3)    read address in, registered data out (latency 1)
//   we_/waddr_/wdata_mem, _alu      write ports; ALU wins an address collision
//   unlock_req, unlock_key, relock  unlock request with key, forced relock
//   unlock_ack, unlock_ok           registered result of an unlock request
//   locked                          high unless the FSM is UNLOCKED
//   viol, viol_count                dropped-write pulse, saturating drop count
//
// Build option: define REGFILE_BYPASS_EN to forward committing write data to
// same-cycle reads of the same address.
module regfile_secure_mp #(
  parameter int              DATA_W         = 32,
  parameter int              ADDR_W         = 5,
  parameter int              KEY_W          = 16,
  parameter logic [KEY_W-1:0] KEY           = 16'h0032,
  parameter int              PROT_BASE      = 24,
  parameter int              PROT_COUNT     = 8,
  parameter int              UNLOCK_CYCLES  = 64,
  parameter int              LOCKOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] rd_addr3,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] rd_data3,
  input  logic              we_mem,
  input  logic [ADDR_W-1:0] waddr_mem,
  input  logic [DATA_W-1:0] wdata_mem,
  input  logic              we_alu,
  input  logic [ADDR_W-1:0] waddr_alu,
  input  logic [DATA_W-1:0] wdata_alu,
  input  logic              unlock_req,
  input  logic [KEY_W-1:0]  unlock_key,
  input  logic              relock,
  output logic              unlock_ack,
  output logic              unlock_ok,
  output logic              locked,
  output logic              viol,
  output logic [7:0]        viol_count
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam int NUM_RD   = 3;
  localparam int TMR_MAX  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {ST_LOCKED, ST_UNLOCKED, ST_PENALTY} state_e;

  state_e                                state_q, state_d;
  logic [TMR_W-1:0]                      timer_q, timer_d;
  logic                                  ack_q, ack_d, ok_q, ok_d;
  logic                                  viol_q, viol_d;
  logic [7:0]                            vcnt_q, vcnt_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]       regs_q, regs_d;
  logic [NUM_RD-1:0][DATA_W-1:0]         rd_data_q, rd_data_d;
  logic [NUM_RD-1:0][ADDR_W-1:0]         rd_addr;

  logic unlocked, mem_prot, alu_prot, mem_viol, alu_viol, mem_ok, alu_ok, same_addr;
  logic [8:0] vsum;

  function automatic logic in_prot(input logic [ADDR_W-1:0] a);
    return (int'(a) >= PROT_BASE) && (int'(a) < PROT_BASE + PROT_COUNT);
  endfunction

  assign rd_addr = {rd_addr3, rd_addr2, rd_addr1};

  // Writes are judged against the current state, so a write issued alongside
  // an accepting unlock_req is still dropped.
  assign unlocked  = (state_q == ST_UNLOCKED);
  assign mem_prot  = in_prot(waddr_mem);
  assign alu_prot  = in_prot(waddr_alu);
  assign same_addr = we_alu && (waddr_alu == waddr_mem);
  assign alu_viol  = we_alu && alu_prot && !unlocked;
  // A memory write shadowed by the ALU write is discarded, never a violation.
  assign mem_viol  = we_mem && mem_prot && !unlocked && !same_addr;
  assign alu_ok    = we_alu && (waddr_alu != '0) && !alu_viol;
  assign mem_ok    = we_mem && (waddr_mem != '0) && !(mem_prot && !unlocked) && !same_addr;

  always_comb begin
    regs_d = regs_q;
    if (mem_ok) regs_d[waddr_mem] = wdata_mem;
    if (alu_ok) regs_d[waddr_alu] = wdata_alu;

    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_d[p] = regs_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (mem_ok && (waddr_mem == rd_addr[p])) rd_data_d[p] = wdata_mem;
      if (alu_ok && (waddr_alu == rd_addr[p])) rd_data_d[p] = wdata_alu;
`endif
      if ((rd_addr[p] == '0) || (in_prot(rd_addr[p]) && !unlocked)) rd_data_d[p] = '0;
    end

    viol_d = mem_viol || alu_viol;
    vsum   = 9'(vcnt_q) + 9'(mem_viol) + 9'(alu_viol);
    vcnt_d = vsum[8] ? 8'hFF : vsum[7:0];
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ack_d   = 1'b0;
    ok_d    = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        if (unlock_req) begin
          ack_d = 1'b1;
          if (unlock_key == KEY) begin
            state_d = ST_UNLOCKED;
            timer_d = TMR_W'(UNLOCK_CYCLES);
            ok_d    = 1'b1;
          end else begin
            state_d = ST_PENALTY;
            timer_d = TMR_W'(LOCKOUT_CYCLES);
          end
        end
      end
      ST_UNLOCKED: begin
        if (relock) begin
          // Relock wins; a concurrent request is answered as rejected.
          state_d = ST_LOCKED;
          timer_d = '0;
          ack_d   = unlock_req;
        end else if (unlock_req && (unlock_key == KEY)) begin
          timer_d = TMR_W'(UNLOCK_CYCLES);
          ack_d   = 1'b1;
          ok_d    = 1'b1;
        end else if (unlock_req) begin
          state_d = ST_PENALTY;
          timer_d = TMR_W'(LOCKOUT_CYCLES);
          ack_d   = 1'b1;
        end else if (timer_q <= TMR_W'(1)) begin
          state_d = ST_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_PENALTY: begin
        ack_d = unlock_req;
        if (timer_q <= TMR_W'(1)) begin
          state_d = ST_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_LOCKED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOCKED;
      timer_q   <= '0;
      ack_q     <= 1'b0;
      ok_q      <= 1'b0;
      viol_q    <= 1'b0;
      vcnt_q    <= '0;
      regs_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ack_q     <= ack_d;
      ok_q      <= ok_d;
      viol_q    <= viol_d;
      vcnt_q    <= vcnt_d;
      regs_q    <= regs_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data1   = rd_data_q[0];
  assign rd_data2   = rd_data_q[1];
  assign rd_data3   = rd_data_q[2];
  assign unlock_ack = ack_q;
  assign unlock_ok  = ok_q;
  assign locked     = (state_q != ST_UNLOCKED);
  assign viol       = viol_q;
  assign viol_count = vcnt_q;
endmodule
